// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative multiply/divide unit.
package cpu_pkg;

  localparam int MDU_OP_W = 2;

  // Encodings match the op_i field driven by the decoder.
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MUL  = 2'b00,
    MDU_MULU = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_DIVU = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes on
// entry and for sign correction of the raw results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Pass the value through or negate it.
  always_comb begin
    result = value;
    if (negate) begin
      result = ~value + W'(1);
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Optional build macro: MDU_EARLY_OUT_EN (multiply finishes as soon as the
// remaining multiplier bits are all zero).
module mdu_iter
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  mdu_state_t        state_r, state_nxt_s;
  mdu_op_t           op_r;
  logic              res_neg_r, rem_neg_r, div0_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r, mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic              busy_r, done_r;
  logic [XLEN-1:0]   hi_r, lo_r;

  logic              op_signed_s, op_div_s, neg1_s, neg2_s, div_zero_s, is_div_r_s;
  logic [XLEN-1:0]   mag1_s, mag2_s;
  logic [XLEN:0]     rem_sh_s, rem_sub_s;
  logic              rem_ge_s;
  logic [2*XLEN-1:0] mul_step_s, div_step_s, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign op_signed_s = ~op_i[0];
  assign op_div_s    = op_i[1];
  assign neg1_s      = op_signed_s & data1_i[XLEN-1];
  assign neg2_s      = op_signed_s & data2_i[XLEN-1];
  assign div_zero_s  = (data2_i == {XLEN{1'b0}});
  assign is_div_r_s  = (op_r == MDU_DIV) || (op_r == MDU_DIVU);

  mdu_sign_fix #(.W(XLEN)) u_mag1 (.value(data1_i), .negate(neg1_s), .result(mag1_s));
  mdu_sign_fix #(.W(XLEN)) u_mag2 (.value(data2_i), .negate(neg2_s), .result(mag2_s));

  mdu_sign_fix #(.W(2*XLEN)) u_prod (.value(acc_r), .negate(res_neg_r), .result(prod_s));
  mdu_sign_fix #(.W(XLEN)) u_quo (.value(acc_r[XLEN-1:0]), .negate(res_neg_r), .result(quo_s));
  mdu_sign_fix #(.W(XLEN)) u_rem (.value(acc_r[2*XLEN-1:XLEN]), .negate(rem_neg_r), .result(rem_s));

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  // For divide, acc_r holds {remainder, dividend/quotient}; mcand_r low half holds the divisor.
  always_comb begin
    rem_sh_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    rem_sub_s = rem_sh_s - {1'b0, mcand_r[XLEN-1:0]};
    rem_ge_s  = (rem_sh_s >= {1'b0, mcand_r[XLEN-1:0]});
    if (mplier_r[0]) begin
      mul_step_s = acc_r + mcand_r;
    end else begin
      mul_step_s = acc_r;
    end
    if (rem_ge_s) begin
      div_step_s = {rem_sub_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      div_step_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush aborts everything except a result already in DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush_i || !start_i) begin
          state_nxt_s = IDLE;
        end else if (op_div_s && div_zero_s) begin
          state_nxt_s = FIX;
`ifdef MDU_EARLY_OUT_EN
        end else if (!op_div_s && (mag2_s == {XLEN{1'b0}})) begin
          state_nxt_s = FIX;
`endif
        end else begin
          state_nxt_s = CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = FIX;
`ifdef MDU_EARLY_OUT_EN
        end else if (!is_div_r_s && (mplier_r[XLEN-1:1] == {(XLEN-1){1'b0}})) begin
          state_nxt_s = FIX;
`endif
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX: begin
        if (flush_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath, operand latching, result commit and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_r      <= MDU_MUL;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      div0_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      mcand_r   <= {(2*XLEN){1'b0}};
      mplier_r  <= {XLEN{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
    end else begin
      busy_r <= (state_nxt_s == CALC) || (state_nxt_s == FIX);
      done_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_r      <= mdu_op_t'(op_i);
            res_neg_r <= neg1_s ^ neg2_s;
            rem_neg_r <= neg1_s;
            div0_r    <= op_div_s & div_zero_s;
            cnt_r     <= CNT_W'(XLEN);
            mcand_r   <= {{XLEN{1'b0}}, (op_div_s ? mag2_s : mag1_s)};
            mplier_r  <= mag2_s;
            if (!op_div_s) begin
              acc_r <= {(2*XLEN){1'b0}};
            end else if (div_zero_s) begin
              // Remainder path carries the dividend straight through to hi_o.
              acc_r <= {mag1_s, {XLEN{1'b0}}};
            end else begin
              acc_r <= {{XLEN{1'b0}}, mag1_s};
            end
          end
        end
        CALC: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (is_div_r_s) begin
            acc_r <= div_step_s;
          end else begin
            acc_r    <= mul_step_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
          end
        end
        FIX: begin
          if (!flush_i) begin
            if (is_div_r_s) begin
              hi_r <= rem_s;
              lo_r <= div0_r ? {XLEN{1'b1}} : quo_s;
            end else begin
              hi_r <= prod_s[2*XLEN-1:XLEN];
              lo_r <= prod_s[XLEN-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN=32).
// Build with +define+MDU_EARLY_OUT_EN to check the early-out multiply latency.
module tb_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i, data2_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int tests_run = 0;
  int tests_failed = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op (start high for one cycle T) and wait for done_o.
  // lat = cycles after T at which done_o is seen (0 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    int k;
    @(negedge clk_i);
    op_i = op; data1_i = a; data2_i = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0; busy_cnt = 0; k = 1;
    while (lat == 0 && k <= 100) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        lat = k;
      end else begin
        @(negedge clk_i);
        k++;
      end
    end
  endtask

  int lat, bcnt, ndone, first;
  int exp_eo;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 2'b00; data1_i = 32'd0; data2_i = 32'd0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_hi", 64'(hi_o), 64'd0);
    check_eq("rst_lo", 64'(lo_o), 64'd0);
    rst_i = 1'b0;

    // MUL 7 * -3
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, lat, bcnt);
    check_eq("mul_lat", 64'(lat), 64'd34);
    check_eq("mul_busy", 64'(bcnt), 64'd33);
    check_eq("mul_hi", 64'(hi_o), 64'hFFFF_FFFF);
    check_eq("mul_lo", 64'(lo_o), 64'hFFFF_FFEB);

    // MUL -5 * -6
    run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, bcnt);
    check_eq("mulnn_hi", 64'(hi_o), 64'd0);
    check_eq("mulnn_lo", 64'(lo_o), 64'd30);

    // DIVU 100 / 7
    run_op(2'b11, 32'd100, 32'd7, lat, bcnt);
    check_eq("divu_lat", 64'(lat), 64'd34);
    check_eq("divu_lo", 64'(lo_o), 64'd14);
    check_eq("divu_hi", 64'(hi_o), 64'd2);

    // DIV -100 / 7
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, lat, bcnt);
    check_eq("div_lo", 64'(lo_o), 64'hFFFF_FFF2);
    check_eq("div_hi", 64'(hi_o), 64'hFFFF_FFFE);

    // DIV 5 / 0
    run_op(2'b10, 32'd5, 32'd0, lat, bcnt);
    check_eq("div0_lat", 64'(lat), 64'd2);
    check_eq("div0_lo", 64'(lo_o), 64'hFFFF_FFFF);
    check_eq("div0_hi", 64'(hi_o), 64'd5);

    // DIV most-negative / -1
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check_eq("ovf_lat", 64'(lat), 64'd34);
    check_eq("ovf_lo", 64'(lo_o), 64'h8000_0000);
    check_eq("ovf_hi", 64'(hi_o), 64'd0);

    // MULU 0x12345678 * 5, and multiply by zero
`ifdef MDU_EARLY_OUT_EN
    exp_eo = 5;
`else
    exp_eo = 34;
`endif
    run_op(2'b01, 32'h1234_5678, 32'd5, lat, bcnt);
    check_eq("eo_lat", 64'(lat), 64'(exp_eo));
    check_eq("eo_lo", 64'(lo_o), 64'h5B05_B058);
    check_eq("eo_hi", 64'(hi_o), 64'd0);
`ifdef MDU_EARLY_OUT_EN
    exp_eo = 2;
`else
    exp_eo = 34;
`endif
    run_op(2'b01, 32'h0000_1234, 32'd0, lat, bcnt);
    check_eq("mz_lat", 64'(lat), 64'(exp_eo));
    check_eq("mz_lo", 64'(lo_o), 64'd0);

    // Flush mid-operation keeps the previous result
    run_op(2'b01, 32'd3, 32'd4, lat, bcnt);
    check_eq("fl_pre_lo", 64'(lo_o), 64'd12);
    @(negedge clk_i);
    op_i = 2'b01; data1_i = 32'hFFFF_FFFF; data2_i = 32'd2; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_eq("fl_busy", 64'(busy_o), 64'd0);
    check_eq("fl_hi", 64'(hi_o), 64'd0);
    check_eq("fl_lo", 64'(lo_o), 64'd12);
    ndone = 0;
    repeat (40) begin
      if (done_o) ndone++;
      @(negedge clk_i);
    end
    check_eq("fl_nodone", 64'(ndone), 64'd0);
    check_eq("fl_keep_lo", 64'(lo_o), 64'd12);
    run_op(2'b01, 32'd2, 32'd2, lat, bcnt);
    check_eq("fl_next_lo", 64'(lo_o), 64'd4);

    // start_i held high through DIVU 9 / 2
    @(negedge clk_i);
    op_i = 2'b11; data1_i = 32'd9; data2_i = 32'd2; start_i = 1'b1;
    @(negedge clk_i);
    ndone = 0; first = 0;
    for (int k = 1; k <= 34; k++) begin
      if (done_o) begin
        ndone++;
        if (first == 0) first = k;
      end
      if (k == 34) begin
        check_eq("hold_lo", 64'(lo_o), 64'd4);
        check_eq("hold_hi", 64'(hi_o), 64'd1);
      end
      @(negedge clk_i);
    end
    check_eq("hold_ndone", 64'(ndone), 64'd1);
    check_eq("hold_first", 64'(first), 64'd34);
    check_eq("hold_idle", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    check_eq("hold_restart", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("mrst_busy", 64'(busy_o), 64'd0);
    check_eq("mrst_done", 64'(done_o), 64'd0);
    check_eq("mrst_hi", 64'(hi_o), 64'd0);
    check_eq("mrst_lo", 64'(lo_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
